// File: rtl/queue_controller_pkg.sv
// Shared constants and slot arithmetic for circular queues built on a register file
// whose slot 0 is the hardwired-zero register.
package queue_controller_pkg;

    localparam int unsigned M_DEFAULT  = 3;
    localparam int unsigned DEPTH      = (1 << M_DEFAULT) - 1;
    localparam int unsigned FIRST_SLOT = 1;

    function automatic int unsigned queue_depth(input int unsigned m);
        return (1 << m) - 1;
    endfunction

    // Successor slot; wraps DEPTH back to FIRST_SLOT so slot 0 is never produced.
    function automatic int unsigned slot_next(input int unsigned a, input int unsigned depth);
        return (a >= depth) ? FIRST_SLOT : a + 1;
    endfunction

    // base + off over the ring 1..depth; valid for off < depth.
    function automatic int unsigned slot_add(input int unsigned base, input int unsigned off,
                                             input int unsigned depth);
        int unsigned s;
        s = base + off;
        return (s > depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/queue_controller_if.sv
// Register-file bus: one write port and two combinational read ports.
interface queue_controller_if #(
    parameter int unsigned M = 3,
    parameter int unsigned N = 4
);
    logic [M-1:0] Write_Address;
    logic [N-1:0] Write_Data;
    logic         Write_Enable;
    logic [M-1:0] Read_Address_0;
    logic [N-1:0] Read_Data_0;
    logic [M-1:0] Read_Address_1;
    logic [N-1:0] Read_Data_1;

    modport master (
        output Write_Address, Write_Data, Write_Enable, Read_Address_0, Read_Address_1,
        input  Read_Data_0, Read_Data_1
    );

    modport slave (
        input  Write_Address, Write_Data, Write_Enable, Read_Address_0, Read_Address_1,
        output Read_Data_0, Read_Data_1
    );
endinterface

// File: rtl/queue_controller_edge_pulse.sv
// Rising-edge detector; history resets to 1 so a level held through reset is not an edge.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 1'b1;
        else        prev <= level;
    end

    assign pulse = level & ~prev;
endmodule

// File: rtl/queue_controller.sv
// Circular FIFO sequencer over a 2R/1W register file (slots 1..2^M-1), with a
// time-multiplexed scan of the occupied entries on read port 1.
module queue_controller
    import queue_controller_pkg::*;
#(
    parameter int unsigned M        = 3,
    parameter int unsigned N        = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    input  logic                Push,
    input  logic                Pop,
    input  logic [N-1:0]        Data_In,
    queue_controller_if.master  rf,
    output logic [N-1:0]        Out_Data,
    output logic                Pop_Valid,
    output logic [M-1:0]        Count,
    output logic                Full,
    output logic                Empty,
    output logic [N-1:0]        Scan_Data,
    output logic [M-1:0]        Scan_Index,
    output logic                Scan_Valid
);
    localparam int unsigned QD = queue_depth(M);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [M-1:0] QD_L   = M'(QD);
    localparam logic [M-1:0] FIRST  = M'(FIRST_SLOT);
    localparam logic [CW-1:0] SC_TC = CW'(SCAN_DIV - 1);

    logic [M-1:0]  head, tail, count, count_nx;
    logic [M-1:0]  head_nx, tail_nx;
    logic [CW-1:0] scan_cnt;
    logic          push_e, pop_e, do_push, do_pop;

    edge_pulse u_push_edge (.clk(CLK100MHZ), .reset(reset), .level(Push), .pulse(push_e));
    edge_pulse u_pop_edge  (.clk(CLK100MHZ), .reset(reset), .level(Pop),  .pulse(pop_e));

    assign Full  = (count == QD_L);
    assign Empty = (count == '0);
    assign Count = count;

    // Push on full is allowed only when a pop frees the same slot at the same edge.
    assign do_push = push_e & (~Full | pop_e);
    assign do_pop  = pop_e & ~Empty;

    assign head_nx = M'(slot_next(32'(head), QD));
    assign tail_nx = M'(slot_next(32'(tail), QD));

    assign rf.Write_Enable   = do_push;
    assign rf.Write_Address  = tail;
    assign rf.Write_Data     = Data_In;
    assign rf.Read_Address_0 = head;
    assign rf.Read_Address_1 = M'(slot_add(32'(head), 32'(Scan_Index), QD));

    assign Scan_Data  = rf.Read_Data_1;
    assign Scan_Valid = ~Empty;

    always_comb begin
        count_nx = count;
        case ({do_push, do_pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            head      <= FIRST;
            tail      <= FIRST;
            count     <= '0;
            Out_Data  <= '0;
            Pop_Valid <= 1'b0;
        end else begin
            if (do_push) tail <= tail_nx;
            if (do_pop) begin
                head     <= head_nx;
                Out_Data <= rf.Read_Data_0;
            end
            Pop_Valid <= do_pop;
            count     <= count_nx;
        end
    end

    // Scan index is kept inside the new occupancy; a shrink past it restarts the scan.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            scan_cnt   <= '0;
            Scan_Index <= '0;
        end else if (count_nx == '0) begin
            Scan_Index <= '0;
            scan_cnt   <= (scan_cnt == SC_TC) ? '0 : scan_cnt + 1'b1;
        end else if ((count_nx != count) && (Scan_Index >= count_nx)) begin
            Scan_Index <= '0;
            scan_cnt   <= '0;
        end else if (scan_cnt == SC_TC) begin
            scan_cnt   <= '0;
            Scan_Index <= (({1'b0, Scan_Index} + 1'b1) >= {1'b0, count_nx}) ? '0
                                                                            : Scan_Index + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_queue_controller.sv
// Self-checking bench: queue-level reference model (SV queue + ring arithmetic) and a
// behavioural register file, with directed boundary scenarios and random push/pop.
module tb_queue_controller;
    localparam int M = 3, N = 4, SD = 4, QD = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic Push = 1'b0, Pop = 1'b0;
    logic [N-1:0] Data_In = '0;
    logic [N-1:0] Out_Data, Scan_Data;
    logic [M-1:0] Count, Scan_Index;
    logic Pop_Valid, Full, Empty, Scan_Valid;

    queue_controller_if #(.M(M), .N(N)) rfb ();

    queue_controller #(.M(M), .N(N), .SCAN_DIV(SD)) dut (
        .CLK100MHZ(clk), .reset(reset), .Push(Push), .Pop(Pop), .Data_In(Data_In),
        .rf(rfb.master), .Out_Data(Out_Data), .Pop_Valid(Pop_Valid), .Count(Count),
        .Full(Full), .Empty(Empty), .Scan_Data(Scan_Data), .Scan_Index(Scan_Index),
        .Scan_Valid(Scan_Valid)
    );

    always #5 clk = ~clk;

    // Behavioural register file, slot 0 reads as zero.
    logic [N-1:0] mem [0:7];
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge clk) if (rfb.Write_Enable && rfb.Write_Address != 0) mem[rfb.Write_Address] <= rfb.Write_Data;
    assign rfb.Read_Data_0 = (rfb.Read_Address_0 == 0) ? '0 : mem[rfb.Read_Address_0];
    assign rfb.Read_Data_1 = (rfb.Read_Address_1 == 0) ? '0 : mem[rfb.Read_Address_1];

    int total = 0, bad = 0;
    int mq[$];
    int head_m = 1, tail_m = 1, out_m = 0;

    function automatic int ring(input int base, input int off);
        return ((base - 1 + off) % QD) + 1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; Push = 1'b0; Pop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mq.delete(); head_m = 1; tail_m = 1; out_m = 0;
        @(negedge clk);
    endtask

    // One request cycle then at least one idle cycle; starts and ends on a falling edge.
    task automatic op(input bit p, input bit q, input int d);
        bit mp, mu;
        Push = p; Pop = q; Data_In = N'(d);
        mp = p && ((mq.size() < QD) || q);
        mu = q && (mq.size() != 0);
        #1;
        total++; if (rfb.Write_Enable !== mp) begin bad++; $display("FAIL we: got %b want %b", rfb.Write_Enable, mp); end
        if (mp) begin
            total++; if (rfb.Write_Address !== M'(tail_m)) begin bad++; $display("FAIL waddr: got %0d want %0d", rfb.Write_Address, tail_m); end
        end
        @(posedge clk); #1;
        Push = 1'b0; Pop = 1'b0;
        if (mu) begin out_m = mq.pop_front(); head_m = ring(head_m, 1); end
        if (mp) begin mq.push_back(d); tail_m = ring(tail_m, 1); end
        @(negedge clk);
        total++; if (Pop_Valid !== mu) begin bad++; $display("FAIL pop_valid: got %b want %b", Pop_Valid, mu); end
        total++; if (Out_Data !== N'(out_m)) begin bad++; $display("FAIL out_data: got %h want %h", Out_Data, out_m); end
        total++; if (Count !== M'(mq.size()) || Full !== (mq.size() == QD) || Empty !== (mq.size() == 0)) begin
            bad++; $display("FAIL count: got %0d/%b/%b want %0d", Count, Full, Empty, mq.size()); end
        total++; if (rfb.Read_Address_0 !== M'(head_m) || rfb.Write_Address !== M'(tail_m)) begin
            bad++; $display("FAIL ptrs: got h%0d t%0d want h%0d t%0d", rfb.Read_Address_0, rfb.Write_Address, head_m, tail_m); end
        total++; if (Scan_Valid !== (mq.size() != 0) || (mq.size() != 0 && int'(Scan_Index) >= mq.size())) begin
            bad++; $display("FAIL scan_idx: got %0d valid %b size %0d", Scan_Index, Scan_Valid, mq.size()); end
        @(negedge clk);
        total++; if (Pop_Valid !== 1'b0) begin bad++; $display("FAIL pop_pulse: got %b want 0", Pop_Valid); end
    endtask

    task automatic test_reset();
        #1;
        total++; if (Count !== 0 || Empty !== 1 || Full !== 0 || Out_Data !== 0 || Pop_Valid !== 0 ||
                     Scan_Index !== 0 || Scan_Valid !== 0 || rfb.Read_Address_0 !== 1 || rfb.Write_Address !== 1) begin
            bad++; $display("FAIL reset: cnt %0d e%b f%b out %h pv %b si %0d h%0d t%0d want 0 1 0 0 0 0 1 1",
                            Count, Empty, Full, Out_Data, Pop_Valid, Scan_Index, rfb.Read_Address_0, rfb.Write_Address); end
        do_reset();
    endtask

    task automatic test_push_pop();
        int v[3] = '{3, 5, 9};
        foreach (v[i]) op(1, 0, v[i]);
        total++; if (mem[1] !== 4'h3 || mem[2] !== 4'h5 || mem[3] !== 4'h9 || rfb.Write_Address !== 3'd4) begin
            bad++; $display("FAIL push3: got %h %h %h tail %0d want 3 5 9 tail 4", mem[1], mem[2], mem[3], rfb.Write_Address); end
        repeat (3) op(0, 1, 0);
        op(0, 1, 0);  // pop on empty: ignored
        total++; if (Out_Data !== 4'h9 || Empty !== 1) begin bad++; $display("FAIL pop_empty: got %h e%b want 9 1", Out_Data, Empty); end
        op(1, 1, 4'hC);  // empty with push+pop: push only
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 7; i++) op(1, 0, i);
        op(1, 0, 4'hA);
        total++; if (mem[1] !== 4'h1) begin bad++; $display("FAIL full_nowrite: got %h want 1", mem[1]); end
        op(1, 1, 4'hA);
        total++; if (mem[1] !== 4'hA || Out_Data !== 4'h1 || Count !== 3'd7) begin
            bad++; $display("FAIL full_swap: got slot1 %h out %h cnt %0d want A 1 7", mem[1], Out_Data, Count); end
    endtask

    task automatic test_scan_wrap();
        int prev, run, trans, seen;
        do_reset();
        repeat (5) op(1, 0, $urandom_range(0, 15));
        repeat (5) op(0, 1, 0);
        for (int i = 0; i < 3; i++) op(1, 0, 8 + i);
        prev = -1; run = 0; trans = 0; seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            total++; if (rfb.Read_Address_1 !== M'(ring(head_m, int'(Scan_Index))) || Scan_Data !== N'(mq[Scan_Index])) begin
                bad++; $display("FAIL scan_addr: got a%0d d%h idx %0d want a%0d", rfb.Read_Address_1, Scan_Data, Scan_Index, ring(head_m, int'(Scan_Index))); end
            seen |= 1 << rfb.Read_Address_1;
            if (prev >= 0 && int'(Scan_Index) != prev) begin
                total++; if (int'(Scan_Index) != (prev + 1) % 3) begin bad++; $display("FAIL scan_step: got %0d want %0d", Scan_Index, (prev + 1) % 3); end
                if (trans > 0) begin
                    total++; if (run != SD) begin bad++; $display("FAIL scan_hold: got %0d want %0d", run, SD); end
                end
                trans++; run = 0;
            end
            prev = int'(Scan_Index); run++;
        end
        total++; if (trans < 8 || seen != ((1 << 6) | (1 << 7) | (1 << 1))) begin
            bad++; $display("FAIL scan_cover: got %0d steps mask %h want >=8 steps mask c2", trans, seen); end
    endtask

    task automatic test_hold();
        do_reset();
        Push = 1'b1; Data_In = 4'h6;
        repeat (10) @(negedge clk);
        Push = 1'b0;
        @(negedge clk);
        total++; if (Count !== 3'd1 || mem[1] !== 4'h6) begin bad++; $display("FAIL hold: got cnt %0d slot1 %h want 1 6", Count, mem[1]); end
        @(negedge clk);
        reset = 1'b0; Push = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        Push = 1'b0;
        @(negedge clk);
        total++; if (Count !== 3'd0 || Empty !== 1'b1) begin bad++; $display("FAIL hold_reset: got cnt %0d want 0", Count); end
        mq.delete(); head_m = 1; tail_m = 1; out_m = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) op(1, 0, i + 2);
        op(0, 1, 0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (Count !== 0 || Out_Data !== 0 || Scan_Index !== 0 || rfb.Read_Address_0 !== 1 || rfb.Write_Address !== 1) begin
            bad++; $display("FAIL async_reset: cnt %0d out %h si %0d h%0d t%0d want 0 0 0 1 1",
                            Count, Out_Data, Scan_Index, rfb.Read_Address_0, rfb.Write_Address); end
        @(negedge clk);
        reset = 1'b1;
        mq.delete(); head_m = 1; tail_m = 1; out_m = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 120; i++) begin
            bit p, q;
            p = ($urandom_range(0, 99) < 60);
            q = ($urandom_range(0, 99) < 45);
            op(p, q, $urandom_range(0, 15));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_full();
        test_scan_wrap();
        test_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
